// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, types and digit-selection helper for the segment scan blocks
package seg_pkg;

  localparam int SEG_DIGITS  = 8;
  localparam int SEG_IDX_W   = 3;
  localparam int SEG_NIB_W   = 4;
  localparam int SEG_IDX_LSB = 0;
  localparam int SEG_NIB_LSB = 3;

  // {wrap, idx}: wrap is set when the scan falls back to the lowest enabled digit
  typedef struct packed {
    logic                 wrap;
    logic [SEG_IDX_W-1:0] idx;
  } seg_next_t;

  // Lowest enabled digit above cur; otherwise lowest enabled overall (a wrap).
  // With no digit enabled the scan holds cur and still reports a wrap.
  function automatic seg_next_t next_enabled(input logic [SEG_IDX_W-1:0] cur,
                                             input logic [SEG_DIGITS-1:0] mask);
    seg_next_t            res;
    logic                 found_hi;
    logic                 found_lo;
    logic [SEG_IDX_W-1:0] hi_idx;
    logic [SEG_IDX_W-1:0] lo_idx;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < SEG_DIGITS; i++) begin
      if (mask[i] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = SEG_IDX_W'(i);
      end
      if (mask[i] && !found_hi && (i > int'(cur))) begin
        found_hi = 1'b1;
        hi_idx   = SEG_IDX_W'(i);
      end
    end
    if (found_hi) begin
      res.wrap = 1'b0;
      res.idx  = hi_idx;
    end else if (found_lo) begin
      res.wrap = 1'b1;
      res.idx  = lo_idx;
    end else begin
      res.wrap = 1'b1;
      res.idx  = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_refresh_prescaler.sv
// rtl/seg_refresh_prescaler.sv - free-running divider producing one tick every REFRESH_DIV cycles
module seg_refresh_prescaler #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_WIDTH   = 17
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  logic [DIV_WIDTH-1:0] div_cnt_q;
  logic [DIV_WIDTH-1:0] div_cnt_d;

  assign tick_o = (div_cnt_q == DIV_WIDTH'(REFRESH_DIV - 1));

  // Count 0..REFRESH_DIV-1, returning to 0 the cycle after the tick
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (tick_o) begin
      div_cnt_d = '0;
    end
  end

  // Divider register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit hex scan driver with frame-aligned shadow commit
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_WIDTH   = 17
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        mask_wr_en,
  input  logic [7:0]  mask_data,
  output logic [31:0] Seg_Display,
  output logic        pending,
  output logic        frame_done
);

  logic                  tick;
  seg_next_t             nxt;
  logic                  commit;

  logic [SEG_IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [SEG_NIB_W-1:0]  nib_q, nib_d;
  logic [SEG_DIGITS-1:0] mask_q, mask_d;
  logic [31:0]           active_q, active_d;
  logic [31:0]           shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;

  seg_refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV),
    .DIV_WIDTH  (DIV_WIDTH)
  ) u_prescaler (
    .clk_i (Clk),
    .rst_ni(Reset),
    .tick_o(tick)
  );

  assign nxt    = next_enabled(cur_idx_q, mask_q);
  assign commit = tick && nxt.wrap && pending_q;

  // Shadow/active update, scan step and nibble selection; a write landing on a
  // committing wrap goes straight to active so the newest value wins
  always_comb begin
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    cur_idx_d    = cur_idx_q;
    nib_d        = nib_q;
    frame_done_d = 1'b0;
    mask_d       = mask_q;
    if (commit) begin
      active_d  = wr_en ? wr_data : shadow_q;
      pending_d = 1'b0;
      if (wr_en) begin
        shadow_d = wr_data;
      end
    end else if (wr_en) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end
    if (tick) begin
      cur_idx_d    = nxt.idx;
      nib_d        = active_d[{nxt.idx, 2'b00} +: SEG_NIB_W];
      frame_done_d = nxt.wrap;
    end
    if (mask_wr_en) begin
      mask_d = mask_data;
    end
  end

  // State registers; reset drops any uncommitted shadow value
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      cur_idx_q    <= '0;
      nib_q        <= '0;
      frame_done_q <= 1'b0;
      mask_q       <= '1;
    end else begin
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      cur_idx_q    <= cur_idx_d;
      nib_q        <= nib_d;
      frame_done_q <= frame_done_d;
      mask_q       <= mask_d;
    end
  end

  // Pack the registered index and nibble into the downstream word layout
  always_comb begin
    Seg_Display = '0;
    Seg_Display[SEG_IDX_LSB +: SEG_IDX_W] = cur_idx_q;
    Seg_Display[SEG_NIB_LSB +: SEG_NIB_W] = nib_q;
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int DIV = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        mask_wr_en = 1'b0;
  logic [7:0]  mask_data = '0;
  logic [31:0] Seg_Display;
  logic        pending;
  logic        frame_done;

  seg_scan_driver #(.REFRESH_DIV(DIV), .DIV_WIDTH(3)) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_data(wr_data),
    .mask_wr_en(mask_wr_en), .mask_data(mask_data),
    .Seg_Display(Seg_Display), .pending(pending), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          fd_seen = 0;
  int          m_cnt, m_cur;
  logic [7:0]  m_mask;
  logic [31:0] m_active, m_shadow, m_disp;
  logic        m_pend, m_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_cur = 0; m_mask = 8'hFF; m_active = '0; m_shadow = '0;
    m_disp = '0; m_pend = 1'b0; m_fd = 1'b0;
  endtask

  // {wrap, idx} from the list of enabled digits
  function automatic logic [3:0] ref_next(input int cur, input logic [7:0] mask);
    int en[$];
    for (int i = 0; i < 8; i++) if (mask[i]) en.push_back(i);
    if (en.size() == 0) return {1'b1, 3'(cur)};
    for (int k = 0; k < en.size(); k++) if (en[k] > cur) return {1'b0, 3'(en[k])};
    return {1'b1, 3'(en[0])};
  endfunction

  function automatic logic wrap_tick_next();
    logic [3:0] nx;
    nx = ref_next(m_cur, m_mask);
    return (m_cnt == DIV - 1) && nx[3];
  endfunction

  task automatic model_edge(input logic wr, input logic [31:0] wd, input logic mw, input logic [7:0] md);
    logic [3:0] nx;
    logic       tk;
    tk = (m_cnt == DIV - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    m_fd = 1'b0;
    if (tk) begin
      nx = ref_next(m_cur, m_mask);
      if (nx[3] && m_pend) begin
        m_active = wr ? wd : m_shadow;
        if (wr) m_shadow = wd;
        m_pend = 1'b0;
      end else if (wr) begin
        m_shadow = wd; m_pend = 1'b1;
      end
      m_cur = int'(nx[2:0]);
      m_fd = nx[3];
      m_disp = (((m_active >> (4 * m_cur)) & 32'hF) << 3) | 32'(m_cur);
    end else if (wr) begin
      m_shadow = wd; m_pend = 1'b1;
    end
    if (mw) m_mask = md;
  endtask

  task automatic step(input logic wr, input logic [31:0] wd, input logic mw, input logic [7:0] md);
    wr_en = wr; wr_data = wd; mask_wr_en = mw; mask_data = md;
    @(posedge Clk);
    model_edge(wr, wd, mw, md);
    #1;
    chk("display", Seg_Display, m_disp);
    chk("pending", {31'b0, pending}, {31'b0, m_pend});
    chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
    if (frame_done === 1'b1) fd_seen++;
    wr_en = 1'b0; mask_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 8'h0);
  endtask

  task automatic wait_cur(input string tag, input int idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      step(1'b0, 32'h0, 1'b0, 8'h0);
      hit = (m_cur == idx) && (m_cnt == 0);
    end
    chk(tag, {31'b0, hit}, 32'h1);
  endtask

  initial begin
    logic [2:0]  seq [4];
    logic [2:0]  exp_seq [4];
    logic [2:0]  held;
    logic        hit;
    int          nseq;
    logic [31:0] rd;

    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_display", Seg_Display, 32'h0);
    chk("reset_pending", {31'b0, pending}, 32'h0);
    chk("reset_frame_done", {31'b0, frame_done}, 32'h0);
    Reset = 1'b1;

    // idle scan with all digits enabled
    idle(4);
    chk("first_tick_index1", Seg_Display, 32'h1);
    fd_seen = 0;
    idle(32);
    chk("fd_per_frame", 32'(fd_seen), 32'h1);

    // mid-frame write while scanning digit 3
    wait_cur("wait_idx3", 3);
    step(1'b1, 32'h8765_4321, 1'b0, 8'h0);
    chk("pending_after_wr", {31'b0, pending}, 32'h1);
    wait_cur("wait_idx4", 4);
    chk("old_digit4", Seg_Display, 32'h4);
    wait_cur("wait_idx0", 0);
    chk("commit_digit0", Seg_Display, 32'h08);
    chk("commit_pending", {31'b0, pending}, 32'h0);
    wait_cur("wait_idx7", 7);
    chk("commit_digit7", Seg_Display, 32'h47);

    // sparse mask: 0,2,7,0
    exp_seq = '{3'd0, 3'd2, 3'd7, 3'd0};
    step(1'b0, 32'h0, 1'b1, 8'b1000_0101);
    fd_seen = 0; nseq = 0; held = Seg_Display[2:0];
    for (int i = 0; i < 64 && nseq < 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 8'h0);
      if (m_cnt == 0) begin seq[nseq] = Seg_Display[2:0]; nseq++; end
    end
    chk("sparse_count", 32'(nseq), 32'd4);
    for (int i = 0; i < 4; i++) chk("sparse_idx", {29'b0, seq[i]}, {29'b0, exp_seq[i]});
    chk("sparse_fd", 32'(fd_seen), 32'd2);

    // empty mask: index held, wrap every tick
    step(1'b0, 32'h0, 1'b1, 8'h00);
    held = Seg_Display[2:0];
    fd_seen = 0;
    idle(16);
    chk("empty_fd", 32'(fd_seen), 32'd4);
    chk("empty_hold", {29'b0, Seg_Display[2:0]}, {29'b0, held});

    // write landing on the committing wrap tick beats the pending value
    step(1'b0, 32'h0, 1'b1, 8'hFF);
    step(1'b1, 32'h5, 1'b0, 8'h0);
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      if (wrap_tick_next()) hit = 1'b1;
      else step(1'b0, 32'h0, 1'b0, 8'h0);
    end
    chk("wait_wrap_tick", {31'b0, hit}, 32'h1);
    step(1'b1, 32'hA, 1'b0, 8'h0);
    chk("direct_digit0", Seg_Display, 32'h50);
    chk("direct_pending", {31'b0, pending}, 32'h0);
    idle(32);

    // asynchronous reset mid-frame with a pending value
    idle(5);
    step(1'b1, $urandom | 32'h1, 1'b0, 8'h0);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    chk("async_display", Seg_Display, 32'h0);
    chk("async_pending", {31'b0, pending}, 32'h0);
    chk("async_frame_done", {31'b0, frame_done}, 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    idle(40);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rd = $urandom;
      step(($urandom_range(0, 5) == 0), rd, ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Upstream scan stage for `Seg_Controller_Int`. It holds an 8-digit hexadecimal display value and steps through the enabled digits at a programmable refresh rate. For each digit it emits the `Seg_Display` word: digit index in bits [2:0] and hex nibble in bits [6:3]. A shadow register commits new values only at frame boundaries, so the display never shows a half-updated number.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz at 100 MHz). Legal range ≥ 2.
- `DIV_WIDTH`, default 17: prescaler width. Must satisfy `REFRESH_DIV-1 < 2**DIV_WIDTH`.

Ports:
- `Clk` in 1: single clock.
- `Reset` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: single-cycle strobe that writes `wr_data` to the shadow register.
- `wr_data` in 32: 8 hex nibbles. Nibble k = bits [4k+3:4k] is shown on digit k.
- `mask_wr_en` in 1: single-cycle strobe that writes `mask_data` to the digit-enable register.
- `mask_data` in 8: bit k=1 enables digit k.
- `Seg_Display` out 32: {25'b0, nibble[3:0], index[2:0]}. Registered.
- `pending` out 1: the shadow register holds a value not yet committed.
- `frame_done` out 1: one-cycle pulse when the scan wraps, i.e. at a frame boundary.

## Operation
- Prescaler `div_cnt` counts 0..REFRESH_DIV-1. `tick`=1 in the cycle where `div_cnt`==REFRESH_DIV-1; the counter returns to 0 on the next cycle.
- On each `tick`, compute `next_idx`:
  - `next_idx` = lowest enabled index greater than `cur_idx`.
  - If there is none, `next_idx` = lowest enabled index overall. This is a wrap, and `frame_done` pulses in the following cycle.
- On the wrap tick, if `pending`=1: `active` <= `shadow`, then `pending` <= 0.
- `Seg_Display` <= {25'b0, active-or-committed nibble at `next_idx`, `next_idx`}. The nibble is taken from the value that is active after the commit in the same tick.
- Write handling:
  - `wr_en` alone: `shadow` <= `wr_data`, `pending` <= 1.
  - `wr_en` in the same cycle as a committing wrap tick: `wr_data` goes directly to `active`, `shadow` <= `wr_data`, `pending` <= 0. The newest value wins.
- Mask write: the new mask is used from the next tick onward. `cur_idx` is not forced to change.
- Mask = 8'h00:
  - Scan holds `cur_idx`.
  - Every tick counts as a wrap: commit allowed, `frame_done` pulses.
  - The nibble output continues to follow `active`.
- Single enabled digit: every tick is a wrap.
- Reset (any time, including mid-frame) clears all state. No partial commit survives reset.

## Timing
- Reset values:
  - `Seg_Display`=32'h0: index 0, nibble 0.
  - `pending`=0, `frame_done`=0.
  - `div_cnt`=0, `cur_idx`=0, `active`=0, `shadow`=0.
  - mask=8'hFF.
- First tick occurs REFRESH_DIV cycles after reset release. `Seg_Display` changes in the cycle after the tick, which gives index 1.
- `pending` rises 1 cycle after `wr_en`.
- Commit latency: `active` updates in the cycle after the next wrap tick. Worst case is one full frame = (enabled digits) × REFRESH_DIV cycles.
- `frame_done` and the `Seg_Display` update for the wrapped index occur in the same cycle.
- Strobes are sampled every cycle. Back-to-back `wr_en`: the last write before the wrap tick wins.

## Structure
- Shared package `seg_pkg`, holding:
  - `SEG_DIGITS`=8, `SEG_IDX_W`=3, `SEG_NIB_W`=4.
  - Field positions `SEG_IDX_LSB`=0 and `SEG_NIB_LSB`=3. `Seg_Controller_Int` decoding must match these.
  - A function `next_enabled(cur, mask)` returning {wrap, idx}.
- One sub-module, `seg_refresh_prescaler`: parameterised counter producing `tick`. Reused by later display blocks.

## Test plan
Bench uses REFRESH_DIV=4.
- Reset, then idle with mask 8'hFF:
  - Indices 1,2,…,7,0 appear at 4-cycle spacing, all nibbles 0.
  - `frame_done` pulses once per 32 cycles.
- Write 32'h8765_4321 mid-frame (scan at index 3):
  - `pending`=1 next cycle.
  - Digits 4..7 still show 0.
  - After the wrap, index 0 shows nibble 1 and index 7 shows nibble 8; `pending`=0.
- Mask 8'b1000_0101:
  - Index sequence is 0,2,7,0,… with `frame_done` on each return to 0.
  - Mask 8'h00 holds the index and pulses `frame_done` every 4 cycles.
- `wr_en` with 32'hA in the wrap-tick cycle while `pending` holds 32'h5:
  - Index 0 shows nibble A.
  - `pending`=0; value 5 is never displayed.
- Assert `Reset` low mid-frame with `pending`=1:
  - All outputs return to their reset values asynchronously.
  - After release, the display shows 0s and `pending`=0.
